mux_2to1: RTL and testbench

- 2-input word multiplexer for the MIPS datapath; selects between two WIDTH-bit operands (e.g. ALU source, write-back source, PC source).
- Provides a combinational output `out` for same-cycle datapath use.
- Also provides a registered copy `out_q` with a valid flag for pipeline-stage use.

---
 rtl/mux_2to1.sv | 69 ++++++
 tb/tb_mux_2to1.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mux_2to1.sv
// Two-input WIDTH-bit word multiplexer with a combinational output and a registered, valid-qualified copy.
// Optional even-parity output on the registered word is enabled by defining MUX_2TO1_PARITY_EN.
module mux_2to1 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             selector,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic             in_valid,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_q,
`ifdef MUX_2TO1_PARITY_EN
   output logic             out_valid,
   output logic             out_parity
`else
   output logic             out_valid
`endif
);

   logic [WIDTH-1:0] w_sel_word;
   logic [WIDTH-1:0] r_out_q;
   logic             r_out_valid;

   // Bitwise select keeps the word strictly lane-aligned: no extension or reordering.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit_mux
         assign w_sel_word[gi] = selector ? in1[gi] : in0[gi];
      end
   endgenerate

   assign out = w_sel_word;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_q     <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_out_q <= w_sel_word;
         end
      end
   end

   assign out_q     = r_out_q;
   assign out_valid = r_out_valid;

`ifdef MUX_2TO1_PARITY_EN
   logic w_sel_parity;
   logic r_out_parity;

   // XOR of the captured word makes {out_q, out_parity} even parity.
   assign w_sel_parity = ^w_sel_word;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_parity <= 1'b0;
      end else if (in_valid) begin
         r_out_parity <= w_sel_parity;
      end
   end

   assign out_parity = r_out_parity;
`endif

endmodule

// File: tb/tb_mux_2to1.sv
// Self-checking bench for mux_2to1: directed plan scenarios followed by randomized cycles against a behavioural model.
// Define MUX_2TO1_PARITY_EN for both bench and RTL to also exercise the parity output.
module tb_mux_2to1;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic             selector;
   logic [WIDTH-1:0] in0;
   logic [WIDTH-1:0] in1;
   logic             in_valid;
   logic [WIDTH-1:0] out;
   logic [WIDTH-1:0] out_q;
   logic             out_valid;
`ifdef MUX_2TO1_PARITY_EN
   logic             out_parity;
`endif

   int total_cnt = 0;
   int bad_cnt   = 0;

   // Behavioural model state: what the registered outputs should hold now.
   logic [WIDTH-1:0] exp_q;
   logic             exp_valid;
   logic             exp_parity;

   mux_2to1 #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .selector  (selector),
      .in0       (in0),
      .in1       (in1),
      .in_valid  (in_valid),
      .out       (out),
      .out_q     (out_q),
`ifdef MUX_2TO1_PARITY_EN
      .out_valid (out_valid),
      .out_parity(out_parity)
`else
      .out_valid (out_valid)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] want);
      total_cnt++;
      if (got !== want) begin
         bad_cnt++;
         $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, want);
      end
   endtask

   function automatic logic [WIDTH-1:0] pick(input logic s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] operands [2];
      operands[0] = a;
      operands[1] = b;
      return operands[s];
   endfunction

   function automatic logic ones_parity(input logic [WIDTH-1:0] w);
      int n = 0;
      for (int i = 0; i < WIDTH; i++) n += int'(w[i]);
      return logic'(n % 2);
   endfunction

   task automatic check_regs(input string tag);
      check_val({tag, ".out_q"}, out_q, exp_q);
      check_val({tag, ".out_valid"}, {{(WIDTH-1){1'b0}}, out_valid}, {{(WIDTH-1){1'b0}}, exp_valid});
`ifdef MUX_2TO1_PARITY_EN
      check_val({tag, ".out_parity"}, {{(WIDTH-1){1'b0}}, out_parity}, {{(WIDTH-1){1'b0}}, exp_parity});
`endif
   endtask

   // Entered just after a rising edge; drives inputs, checks the combinational path,
   // advances the model across the next edge and checks the registers.
   task automatic cycle(input string tag, input logic r, input logic v, input logic s,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] sel_word;
      rst = r; in_valid = v; selector = s; in0 = a; in1 = b;
      #1;
      sel_word = pick(s, a, b);
      check_val({tag, ".out"}, out, sel_word);
      @(posedge clk);
      if (r) begin
         exp_q = '0; exp_valid = 1'b0; exp_parity = 1'b0;
      end else begin
         exp_valid = v;
         if (v) begin
            exp_q      = sel_word;
            exp_parity = ones_parity(sel_word);
         end
      end
      #1;
      check_regs(tag);
   endtask

   initial begin
      rst = 1'b1; selector = 1'b0; in0 = '0; in1 = '0; in_valid = 1'b0;
      exp_q = '0; exp_valid = 1'b0; exp_parity = 1'b0;
      @(posedge clk); #1;

      // Power-up reset then a 100 ns idle hold
      cycle("reset0", 1'b1, 1'b0, 1'b0, '0, '0);
      cycle("reset1", 1'b1, 1'b0, 1'b0, '0, '0);
      rst = 1'b0;
      #100;
      check_val("idle.out", out, 32'h0000_0000);
      check_regs("idle");
      @(posedge clk); #1;

      // Combinational select with no clock edge in between
      in0 = 32'hDEAD_BEEF; in1 = 32'h1234_5678; selector = 1'b0;
      #1 check_val("comb.sel0", out, 32'hDEAD_BEEF);
      selector = 1'b1;
      #0 check_val("comb.sel1", out, 32'h1234_5678);
      @(posedge clk); #1;

      // Single capture then a hold cycle
      cycle("cap", 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678);
      check_val("cap.q_const", out_q, 32'h1234_5678);
      cycle("hold", 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678);
      check_val("hold.q_const", out_q, 32'h1234_5678);

      // Back-to-back captures with selector 0,1,0
      cycle("b2b0", 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
      cycle("b2b1", 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678);
      cycle("b2b2", 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678);

      // Reset wins over in_valid; out keeps following inputs during reset
      cycle("rstprio", 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678);
      check_val("rstprio.q_zero", out_q, 32'h0000_0000);

      // Parity-oriented captures (parity checked only when the feature is built)
      cycle("par7", 1'b0, 1'b1, 1'b0, 32'h0000_0007, 32'hFFFF_0000);
      cycle("par3", 1'b0, 1'b1, 1'b1, 32'hFFFF_0000, 32'h0000_0003);
      cycle("parhold", 1'b0, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0003);
      cycle("parrst", 1'b1, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0003);

      // Randomized traffic with occasional mid-stream reset
      for (int n = 0; n < 300; n++) begin
         cycle("rand", ($urandom_range(15) == 0), logic'($urandom_range(1)), logic'($urandom_range(1)),
               $urandom, $urandom);
      end

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

   // Hard time limit so the bench can never hang.
   initial begin
      #200000;
      $display("FAIL timeout: got=running want=finished");
      $fatal(1, "time limit reached");
   end

endmodule
